// File: rtl/fetch_stage_pkg.sv
// Shared RV32 front-end constants: opcode encodings (also used by the main decoder),
// the canonical NOP and the fetch state encoding.
package fetch_stage_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_R_TYPE = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_I_TYPE = 7'b0010011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_ENC = 32'h0000_0013;

    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t S_REQ  = 2'd0;
    localparam fetch_state_t S_WAIT = 2'd1;
    localparam fetch_state_t S_HOLD = 2'd2;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load, stall-hold and flush-to-NOP, plus the
// opcode/funct3 pre-split handed to decode.
module fetch_stage_if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_ENC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic        i_flush,
    input  logic        i_stall,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [6:0]  o_opcode,
    output logic [2:0]  o_funct3,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4
);

    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic [31:0] r_pc_plus4;

    // Flush wins over everything; stall only matters when nothing is loaded.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid    <= 1'b0;
            r_instr    <= NOP_INSTR;
            r_pc       <= '0;
            r_pc_plus4 <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
        end else if (i_load) begin
            r_valid    <= 1'b1;
            r_instr    <= i_instr;
            r_pc       <= i_pc;
            r_pc_plus4 <= i_pc + 32'd4;
        end else if (!i_stall) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
        end
    end

    assign o_valid    = r_valid;
    assign o_instr    = r_instr;
    assign o_opcode   = r_instr[6:0];
    assign o_funct3   = r_instr[14:12];
    assign o_pc       = r_pc;
    assign o_pc_plus4 = r_pc_plus4;

endmodule

// File: rtl/fetch_stage.sv
// RV32 instruction fetch with one outstanding imem request and the IF/ID register.
// Define FETCH_PERF_EN to add the fetch/flush/stall performance counters.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_ENC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [6:0]  id_opcode,
    output logic [2:0]  id_funct3,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_flush_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    fetch_state_t r_state;
    logic [31:0]  r_fetch_pc;
    logic [31:0]  r_req_pc;
    logic         r_discard;
    logic [31:0]  r_hold_instr;
    logic [31:0]  r_hold_pc;

    logic         w_hs;
    logic         w_load_rsp;
    logic         w_load_hold;
    logic         w_load;
    logic [31:0]  w_load_instr;
    logic [31:0]  w_load_pc;
    logic         w_unused;

    assign imem_req_valid = (r_state == S_REQ) && !reset;
    assign imem_addr      = r_fetch_pc;
    assign w_hs           = imem_req_valid && imem_req_ready;
    assign w_unused       = ^redirect_pc[1:0];

    assign w_load_rsp   = (r_state == S_WAIT) && imem_rsp_valid && !r_discard
                          && !stall && !redirect_valid;
    assign w_load_hold  = (r_state == S_HOLD) && !stall && !redirect_valid;
    assign w_load       = w_load_rsp || w_load_hold;
    assign w_load_instr = w_load_hold ? r_hold_instr : imem_rsp_data;
    assign w_load_pc    = w_load_hold ? r_hold_pc : r_req_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_REQ;
            r_fetch_pc   <= RESET_PC;
            r_req_pc     <= '0;
            r_discard    <= 1'b0;
            r_hold_instr <= NOP_INSTR;
            r_hold_pc    <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc   <= {redirect_pc[31:2], 2'b00};
            r_hold_instr <= NOP_INSTR;
            r_hold_pc    <= '0;
            case (r_state)
                S_WAIT: begin
                    // A response landing with the redirect is simply dropped.
                    if (imem_rsp_valid) begin
                        r_state   <= S_REQ;
                        r_discard <= 1'b0;
                    end else begin
                        r_discard <= 1'b1;
                    end
                end
                S_HOLD: r_state <= S_REQ;
                default: begin
                    if (w_hs) begin
                        r_state   <= S_WAIT;
                        r_discard <= 1'b1;
                    end
                end
            endcase
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_hs) begin
                        r_req_pc   <= r_fetch_pc;
                        r_fetch_pc <= r_fetch_pc + 32'd4;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (r_discard) begin
                            r_discard <= 1'b0;
                            r_state   <= S_REQ;
                        end else if (stall) begin
                            r_hold_instr <= imem_rsp_data;
                            r_hold_pc    <= r_req_pc;
                            r_state      <= S_HOLD;
                        end else begin
                            r_state <= S_REQ;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) r_state <= S_REQ;
                end
                default: r_state <= S_REQ;
            endcase
        end
    end

    fetch_stage_if_id_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_load),
        .i_flush   (redirect_valid),
        .i_stall   (stall),
        .i_instr   (w_load_instr),
        .i_pc      (w_load_pc),
        .o_valid   (id_valid),
        .o_instr   (id_instr),
        .o_opcode  (id_opcode),
        .o_funct3  (id_funct3),
        .o_pc      (id_pc),
        .o_pc_plus4(id_pc_plus4)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_flush;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_fetch <= '0;
            r_perf_flush <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_load)             r_perf_fetch <= r_perf_fetch + 32'd1;
            if (redirect_valid)     r_perf_flush <= r_perf_flush + 32'd1;
            if (stall && id_valid)  r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_fetch_cnt = r_perf_fetch;
    assign perf_flush_cnt = r_perf_flush;
    assign perf_stall_cnt = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a behavioural imem answers accepted requests,
// expected request addresses and IF/ID contents are queued by the stimulus and checked by monitors.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [6:0]  id_opcode;
    logic [2:0]  id_funct3;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
    logic [31:0] perf_stall_cnt;
    int          m_fetch = 0;
    int          m_flush = 0;
    int          m_stall = 0;
    logic        prev_valid = 1'b0;
`endif

    int          vectors = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rsp_delay = 0;
    int          last_load_cyc = 0;
    int          rel_cyc = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_id_q[$];

    fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr     (imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .stall         (stall),
        .id_valid      (id_valid),
        .id_instr      (id_instr),
        .id_opcode     (id_opcode),
        .id_funct3     (id_funct3),
        .id_pc         (id_pc),
        .id_pc_plus4   (id_pc_plus4)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_flush_cnt(perf_flush_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0050_0093;
            32'h0000_0004: return 32'h0010_0113;
            32'h0000_0008: return 32'h0020_81b3;
            32'h0000_000C: return 32'h0031_2023;
            32'h0000_0100: return 32'h00c0_00ef;
            32'h0000_0104: return 32'h1234_5037;
            32'h0000_0200: return 32'h0020_8463;
            default:       return {a[21:2], 12'h2b3};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // imem model: response strobe at negedge+1, request acceptance observed at negedge+4
    initial begin
        logic        pend;
        int          cnt;
        logic [31:0] paddr;
        pend  = 1'b0;
        cnt   = 0;
        paddr = '0;
        forever begin
            @(negedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            if (pend) begin
                if (cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = imem_word(paddr);
                    pend           = 1'b0;
                end else begin
                    cnt--;
                end
            end
            #3;
            if (imem_req_valid && imem_req_ready) begin
                pend  = 1'b1;
                cnt   = rsp_delay;
                paddr = imem_addr;
                if (exp_addr_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL req_addr: got unexpected request %h expected none", imem_addr);
                end else begin
                    check("req_addr", imem_addr, exp_addr_q.pop_front());
                end
            end
        end
    end

    // IF/ID monitor: a new instruction is present when id_valid follows an unstalled edge
    initial begin
        logic [31:0] pc;
        logic [31:0] w;
        forever begin
            @(negedge clk);
            if (id_valid && !stall) begin
                if (exp_id_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL id_load: got unexpected pc %h instr %h expected none", id_pc, id_instr);
                end else begin
                    pc = exp_id_q.pop_front();
                    w  = imem_word(pc);
                    check("id_pc", id_pc, pc);
                    check("id_instr", id_instr, w);
                    check("id_opcode", {25'b0, id_opcode}, {25'b0, w[6:0]});
                    check("id_funct3", {29'b0, id_funct3}, {29'b0, w[14:12]});
                    check("id_pc_plus4", id_pc_plus4, pc + 32'd4);
                end
                last_load_cyc = cyc;
            end
`ifdef FETCH_PERF_EN
            if (reset) begin
                m_fetch = 0;
                m_flush = 0;
                m_stall = 0;
            end else begin
                if (id_valid && !stall) m_fetch++;
                if (redirect_valid)     m_flush++;
                if (prev_valid && stall) m_stall++;
            end
            prev_valid = id_valid;
`endif
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
        #3;
    endtask

    task automatic wait_req(input logic [31:0] a);
        int n;
        n = 0;
        while (!(imem_req_valid && imem_addr == a) && n < 60) begin
            step();
            n++;
        end
        if (n >= 60) begin
            vectors++;
            errors++;
            $display("FAIL wait_req: got no request expected addr %h", a);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_id_q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        check("id_queue_empty", exp_id_q.size(), 0);
        check("addr_queue_empty", exp_addr_q.size(), 0);
`ifdef FETCH_PERF_EN
        check("perf_fetch", perf_fetch_cnt, m_fetch);
        check("perf_flush", perf_flush_cnt, m_flush);
        check("perf_stall", perf_stall_cnt, m_stall);
`endif
        exp_id_q.delete();
        exp_addr_q.delete();
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        step();
        step();
        check("rst_id_valid", id_valid, 0);
        check("rst_id_instr", id_instr, 32'h0000_0013);
        check("rst_id_pc", id_pc, 0);
        check("rst_id_pc_plus4", id_pc_plus4, 0);
        check("rst_req_valid", imem_req_valid, 0);
`ifdef FETCH_PERF_EN
        check("rst_perf_fetch", perf_fetch_cnt, 0);
        check("rst_perf_flush", perf_flush_cnt, 0);
        check("rst_perf_stall", perf_stall_cnt, 0);
`endif
        reset   = 1'b0;
        rel_cyc = cyc;
    endtask

    initial begin
        // straight-line fetch, zero-wait memory
        do_reset();
        rsp_delay = 0;
        exp_addr_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        exp_id_q   = '{32'h0, 32'h4, 32'h8, 32'hC};
        drain();
        check("throughput_cycle", last_load_cyc, rel_cyc + 8);

        // ready held low at 0x8
        do_reset();
        exp_addr_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        exp_id_q   = '{32'h0, 32'h4, 32'h8, 32'hC};
        wait_req(32'h8);
        imem_req_ready = 1'b0;
        repeat (3) begin
            step();
            check("ready_low_addr", imem_addr, 32'h8);
            check("ready_low_valid", imem_req_valid, 1);
        end
        imem_req_ready = 1'b1;
        drain();

        // response for 0x4 arrives under stall
        do_reset();
        exp_addr_q = '{32'h0, 32'h4, 32'h8};
        exp_id_q   = '{32'h0, 32'h4, 32'h8};
        wait_req(32'h4);
        stall = 1'b1;
        step();
        step();
        repeat (2) begin
            step();
            check("hold_no_req", imem_req_valid, 0);
            check("hold_id_valid", id_valid, 1);
            check("hold_id_pc", id_pc, 32'h0);
        end
        stall = 1'b0;
        step();
        check("unstall_id_valid", id_valid, 1);
        check("unstall_id_pc", id_pc, 32'h4);
        check("unstall_req_addr", imem_addr, 32'h8);
        check("unstall_req_valid", imem_req_valid, 1);
        drain();

        // redirect to 0x103 while waiting for 0x8 (slow memory)
        do_reset();
        rsp_delay = 2;
        exp_addr_q = '{32'h0, 32'h4, 32'h8, 32'h100, 32'h104};
        exp_id_q   = '{32'h0, 32'h4, 32'h100, 32'h104};
        wait_req(32'h8);
        step();
        redirect_pc    = 32'h103;
        redirect_valid = 1'b1;
        step();
        redirect_valid = 1'b0;
        check("wait_redirect_valid", id_valid, 0);
        check("wait_redirect_instr", id_instr, 32'h0000_0013);
        drain();
        rsp_delay = 0;

        // redirect coincident with a response, then redirect from S_HOLD under stall
        do_reset();
        exp_addr_q = '{32'h0, 32'h4, 32'h200, 32'h204, 32'h300};
        exp_id_q   = '{32'h0, 32'h200, 32'h300};
        wait_req(32'h4);
        step();
        check("rsp_present", imem_rsp_valid, 1);
        redirect_pc    = 32'h200;
        redirect_valid = 1'b1;
        step();
        redirect_valid = 1'b0;
        check("rsp_redirect_valid", id_valid, 0);
        check("rsp_redirect_addr", imem_addr, 32'h200);
        check("rsp_redirect_req", imem_req_valid, 1);
        wait_req(32'h204);
        stall = 1'b1;
        step();
        step();
        check("stall_hold_valid", id_valid, 1);
        redirect_pc    = 32'h300;
        redirect_valid = 1'b1;
        step();
        redirect_valid = 1'b0;
        check("stall_redirect_valid", id_valid, 0);
        check("stall_redirect_addr", imem_addr, 32'h300);
        step();
        stall = 1'b0;
        drain();

        // redirect coinciding with the first handshake
        do_reset();
        exp_addr_q = '{32'h0, 32'h100, 32'h104};
        exp_id_q   = '{32'h100, 32'h104};
        redirect_pc    = 32'h100;
        redirect_valid = 1'b1;
        step();
        redirect_valid = 1'b0;
        check("hs_redirect_valid", id_valid, 0);
        drain();

        // address wrap at the top of memory
        do_reset();
        imem_req_ready = 1'b0;
        step();
        redirect_pc    = 32'hFFFF_FFFF;
        redirect_valid = 1'b1;
        step();
        redirect_valid = 1'b0;
        check("wrap_target_addr", imem_addr, 32'hFFFF_FFFC);
        exp_addr_q = '{32'hFFFF_FFFC, 32'h0};
        exp_id_q   = '{32'hFFFF_FFFC, 32'h0};
        imem_req_ready = 1'b1;
        drain();

        reset = 1'b1;
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
